// File: rtl/alu_if.sv
// Issue and CDB signals between the reservation station, the ALU and the CDB snoopers.
// The master side issues ops and snoops the ALU half of the CDB; the slave side is the ALU.
interface alu_if #(
  parameter int RS_TYPE_BIT  = 4,
  parameter int ROB_SIZE_BIT = 4
);
  logic                    alu_input;
  logic [RS_TYPE_BIT-1:0]  arith_type;
  logic [31:0]             alu_r1_val;
  logic [31:0]             alu_r2_val;
  logic [ROB_SIZE_BIT-1:0] inst_rob_id;
  logic                    rs_fi;
  logic [31:0]             rs_value;
  logic [ROB_SIZE_BIT-1:0] rs_rob_id;

  modport master (
    output alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    input  rs_fi, rs_value, rs_rob_id
  );

  modport slave (
    input  alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    output rs_fi, rs_value, rs_rob_id
  );
endinterface

// File: rtl/alu.sv
// RV32I integer execute stage driving the ALU half of the CDB, one op per cycle.
// Define ALU_PIPE2_EN to add a registered operand stage (2-cycle latency).
module alu #(
  parameter int RS_TYPE_BIT  = 4,
  parameter int ROB_SIZE_BIT = 4
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  input  logic  rob_clear,
  alu_if.slave  bus
);

  localparam logic [RS_TYPE_BIT-1:0] OP_ADD  = RS_TYPE_BIT'(0);
  localparam logic [RS_TYPE_BIT-1:0] OP_SUB  = RS_TYPE_BIT'(1);
  localparam logic [RS_TYPE_BIT-1:0] OP_SLL  = RS_TYPE_BIT'(2);
  localparam logic [RS_TYPE_BIT-1:0] OP_SLT  = RS_TYPE_BIT'(3);
  localparam logic [RS_TYPE_BIT-1:0] OP_SLTU = RS_TYPE_BIT'(4);
  localparam logic [RS_TYPE_BIT-1:0] OP_XOR  = RS_TYPE_BIT'(5);
  localparam logic [RS_TYPE_BIT-1:0] OP_SRL  = RS_TYPE_BIT'(6);
  localparam logic [RS_TYPE_BIT-1:0] OP_SRA  = RS_TYPE_BIT'(7);
  localparam logic [RS_TYPE_BIT-1:0] OP_OR   = RS_TYPE_BIT'(8);
  localparam logic [RS_TYPE_BIT-1:0] OP_AND  = RS_TYPE_BIT'(9);
  localparam logic [RS_TYPE_BIT-1:0] OP_BEQ  = RS_TYPE_BIT'(10);
  localparam logic [RS_TYPE_BIT-1:0] OP_BNE  = RS_TYPE_BIT'(11);
  localparam logic [RS_TYPE_BIT-1:0] OP_BLT  = RS_TYPE_BIT'(12);
  localparam logic [RS_TYPE_BIT-1:0] OP_BGE  = RS_TYPE_BIT'(13);
  localparam logic [RS_TYPE_BIT-1:0] OP_BLTU = RS_TYPE_BIT'(14);
  localparam logic [RS_TYPE_BIT-1:0] OP_BGEU = RS_TYPE_BIT'(15);

  // Compare and branch ops return the outcome in bit 0; branches report "taken".
  function automatic logic [31:0] alu_compute(
    input logic [RS_TYPE_BIT-1:0] op,
    input logic [31:0]            a,
    input logic [31:0]            b
  );
    logic [4:0]  sh;
    logic [31:0] res;
    sh  = b[4:0];
    res = 32'd0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << sh;
      OP_SLT:  res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: res = {31'd0, a < b};
      OP_XOR:  res = a ^ b;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $signed(a) >>> sh;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_BEQ:  res = {31'd0, a == b};
      OP_BNE:  res = {31'd0, a != b};
      OP_BLT:  res = {31'd0, $signed(a) < $signed(b)};
      OP_BGE:  res = {31'd0, $signed(a) >= $signed(b)};
      OP_BLTU: res = {31'd0, a < b};
      OP_BGEU: res = {31'd0, a >= b};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  logic                    ex_valid_s;
  logic [RS_TYPE_BIT-1:0]  ex_type_s;
  logic [31:0]             ex_r1_s;
  logic [31:0]             ex_r2_s;
  logic [ROB_SIZE_BIT-1:0] ex_id_s;
  logic [31:0]             ex_result_s;

  logic                    rs_fi_r;
  logic [31:0]             rs_value_r;
  logic [ROB_SIZE_BIT-1:0] rs_rob_id_r;

`ifdef ALU_PIPE2_EN
  logic                    op_valid_r;
  logic [RS_TYPE_BIT-1:0]  op_type_r;
  logic [31:0]             op_r1_r;
  logic [31:0]             op_r2_r;
  logic [ROB_SIZE_BIT-1:0] op_id_r;

  // Operand stage: a flush kills the op being captured as well as the one held here.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op_valid_r <= 1'b0;
      op_type_r  <= '0;
      op_r1_r    <= 32'd0;
      op_r2_r    <= 32'd0;
      op_id_r    <= '0;
    end else if (rdy_in) begin
      op_valid_r <= bus.alu_input & ~rob_clear;
      if (bus.alu_input) begin
        op_type_r <= bus.arith_type;
        op_r1_r   <= bus.alu_r1_val;
        op_r2_r   <= bus.alu_r2_val;
        op_id_r   <= bus.inst_rob_id;
      end
    end
  end

  assign ex_valid_s = op_valid_r;
  assign ex_type_s  = op_type_r;
  assign ex_r1_s    = op_r1_r;
  assign ex_r2_s    = op_r2_r;
  assign ex_id_s    = op_id_r;
`else
  assign ex_valid_s = bus.alu_input;
  assign ex_type_s  = bus.arith_type;
  assign ex_r1_s    = bus.alu_r1_val;
  assign ex_r2_s    = bus.alu_r2_val;
  assign ex_id_s    = bus.inst_rob_id;
`endif

  assign ex_result_s = alu_compute(ex_type_s, ex_r1_s, ex_r2_s);

  // CDB register: value and id keep their last beat when idle, so consumers gate on rs_fi.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rs_fi_r     <= 1'b0;
      rs_value_r  <= 32'd0;
      rs_rob_id_r <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        rs_fi_r <= 1'b0;
      end else begin
        rs_fi_r <= ex_valid_s;
        if (ex_valid_s) begin
          rs_value_r  <= ex_result_s;
          rs_rob_id_r <= ex_id_s;
        end
      end
    end
  end

  assign bus.rs_fi     = rs_fi_r;
  assign bus.rs_value  = rs_value_r;
  assign bus.rs_rob_id = rs_rob_id_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus random traffic against an arithmetic model.
// Expected latency follows ALU_PIPE2_EN.
module tb_alu;

`ifdef ALU_PIPE2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int DEPTH = 4096;
  localparam longint M = 64'sh1_0000_0000;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic rob_clear;

  alu_if #(.RS_TYPE_BIT(4), .ROB_SIZE_BIT(4)) bus ();

  alu #(.RS_TYPE_BIT(4), .ROB_SIZE_BIT(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  always #5 clk_in = ~clk_in;

  // Model: expected CDB beat per enabled-edge index, plus the current expected outputs.
  logic        exp_v   [DEPTH];
  logic [31:0] exp_val [DEPTH];
  logic [3:0]  exp_id  [DEPTH];
  int          en_cnt;
  logic        cur_fi;
  logic [31:0] cur_val;
  logic [3:0]  cur_id;
  logic [31:0] beats[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] ref_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = a[31] ? ua - M : ua;
    sb = b[31] ? ub - M : ub;
    p  = 64'sd1;
    for (int i = 0; i < int'(b[4:0]); i++) p = p * 64'sd2;
    case (t)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub + M;
      4'd2:    r = ua * p;
      4'd3:    r = (sa < sb) ? 64'sd1 : 64'sd0;
      4'd4:    r = (ua < ub) ? 64'sd1 : 64'sd0;
      4'd5:    r = longint'({32'd0, a ^ b});
      4'd6:    r = ua / p;
      4'd7:    r = (sa >= 64'sd0) ? sa / p : M - ((-sa + p - 64'sd1) / p);
      4'd8:    r = longint'({32'd0, a | b});
      4'd9:    r = longint'({32'd0, a & b});
      4'd10:   r = (ua == ub) ? 64'sd1 : 64'sd0;
      4'd11:   r = (ua != ub) ? 64'sd1 : 64'sd0;
      4'd12:   r = (sa < sb) ? 64'sd1 : 64'sd0;
      4'd13:   r = (sa >= sb) ? 64'sd1 : 64'sd0;
      4'd14:   r = (ua < ub) ? 64'sd1 : 64'sd0;
      4'd15:   r = (ua >= ub) ? 64'sd1 : 64'sd0;
      default: r = 64'sd0;
    endcase
    r = r % M;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      exp_v[k]   = 1'b0;
      exp_val[k] = 32'd0;
      exp_id[k]  = 4'd0;
    end
    en_cnt  = 0;
    cur_fi  = 1'b0;
    cur_val = 32'd0;
    cur_id  = 4'd0;
  endtask

  task automatic step(input logic v, input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] id, input logic clr, input logic rdy);
    bus.alu_input   = v;
    bus.arith_type  = t;
    bus.alu_r1_val  = a;
    bus.alu_r2_val  = b;
    bus.inst_rob_id = id;
    rob_clear       = clr;
    rdy_in          = rdy;
    @(posedge clk_in);
    if (rdy) begin
      if (clr) begin
        for (int k = en_cnt; k < en_cnt + L && k < DEPTH; k++) exp_v[k] = 1'b0;
      end else if (v && (en_cnt + L - 1 < DEPTH)) begin
        exp_v[en_cnt + L - 1]   = 1'b1;
        exp_val[en_cnt + L - 1] = ref_op(t, a, b);
        exp_id[en_cnt + L - 1]  = id;
      end
      cur_fi = (en_cnt < DEPTH) ? exp_v[en_cnt] : 1'b0;
      if (cur_fi) begin
        cur_val = exp_val[en_cnt];
        cur_id  = exp_id[en_cnt];
      end
      en_cnt++;
    end
    #1;
    chk("rs_fi", {31'd0, bus.rs_fi}, {31'd0, cur_fi});
    chk("rs_value", bus.rs_value, cur_val);
    chk("rs_rob_id", {28'd0, bus.rs_rob_id}, {28'd0, cur_id});
    if (rdy && bus.rs_fi === 1'b1) beats.push_back(bus.rs_value);
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic [3:0] id);
    step(1'b1, t, a, b, id, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
  endtask

  logic [31:0] edge_ops [5];
  logic [31:0] ra, rb;

  initial begin
    edge_ops[0] = 32'h0000_0000;
    edge_ops[1] = 32'h0000_0001;
    edge_ops[2] = 32'h7FFF_FFFF;
    edge_ops[3] = 32'h8000_0000;
    edge_ops[4] = 32'hFFFF_FFFF;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob_clear = 1'b0;
    bus.alu_input = 1'b0;
    bus.arith_type = 4'd0;
    bus.alu_r1_val = 32'd0;
    bus.alu_r2_val = 32'd0;
    bus.inst_rob_id = 4'd0;
    model_reset();
    #3;
    chk("reset_fi", {31'd0, bus.rs_fi}, 32'd0);
    chk("reset_value", bus.rs_value, 32'd0);
    chk("reset_id", {28'd0, bus.rs_rob_id}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // ADD wraps; beat appears L edges after issue and lasts one cycle
    issue(4'd0, 32'hFFFF_FFFF, 32'd2, 4'd3);
    for (int i = 1; i < L; i++) idle();
    chk("add_fi", {31'd0, bus.rs_fi}, 32'd1);
    chk("add_value", bus.rs_value, 32'h0000_0001);
    chk("add_id", {28'd0, bus.rs_rob_id}, 32'd3);
    idle();
    chk("add_fi_drop", {31'd0, bus.rs_fi}, 32'd0);

    beats.delete();
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd4);
    issue(4'd6, 32'h8000_0000, 32'h0000_0024, 4'd5);
    for (int i = 0; i < L; i++) idle();
    chk("shift_beats", beats.size(), 32'd2);
    if (beats.size() == 2) begin
      chk("sra_value", beats[0], 32'hF800_0000);
      chk("srl_value", beats[1], 32'h0800_0000);
    end

    beats.delete();
    issue(4'd14, 32'd1, 32'hFFFF_FFFF, 4'd6);
    issue(4'd12, 32'd1, 32'hFFFF_FFFF, 4'd7);
    issue(4'd1, 32'd0, 32'd1, 4'd8);
    for (int i = 0; i < L; i++) idle();
    chk("cmp_beats", beats.size(), 32'd3);
    if (beats.size() == 3) begin
      chk("bltu_value", beats[0], 32'd1);
      chk("blt_value", beats[1], 32'd0);
      chk("sub_value", beats[2], 32'hFFFF_FFFF);
    end

    // Flush arrives with the third op: only ops already retired may have beaten
    beats.delete();
    issue(4'd0, 32'd10, 32'd1, 4'd1);
    issue(4'd0, 32'd20, 32'd2, 4'd2);
    step(1'b1, 4'd0, 32'd30, 32'd3, 4'd9, 1'b1, 1'b1);
    chk("flush_fi", {31'd0, bus.rs_fi}, 32'd0);
    for (int i = 0; i < L; i++) idle();
    chk("flush_beats", beats.size(), 32'(3 - L));

    beats.delete();
    issue(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) idle();
    chk("stall_beats", beats.size(), 32'd1);
    if (beats.size() == 1) chk("stall_value", beats[0], 32'h0FF0_0FF0);

    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_ops[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_ops[$urandom_range(0, 4)] : $urandom;
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), ra, rb, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0));
    end

    // Asynchronous reset while a beat is on the bus
    issue(4'd8, 32'h1234_0000, 32'h0000_5678, 4'd12);
    for (int i = 1; i < L; i++) idle();
    chk("pre_reset_fi", {31'd0, bus.rs_fi}, 32'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("async_reset_fi", {31'd0, bus.rs_fi}, 32'd0);
    chk("async_reset_value", bus.rs_value, 32'd0);
    chk("async_reset_id", {28'd0, bus.rs_rob_id}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
